// File: rtl/cpu16_mem_arb_if.sv
// cpu16_mem_arb_if: fetch, data and SRAM signal bundle around the cpu16 memory arbiter
interface cpu16_mem_arb_if;
    logic [15:0] ins_rd_addr;
    logic        ins_rd_req;
    logic [15:0] ins_rd_data;
    logic        ins_rd_rdy;
    logic [15:0] dat_rw_addr;
    logic [15:0] dat_wr_data;
    logic        dat_rd_req;
    logic        dat_wr_req;
    logic [15:0] dat_rd_data;
    logic        dat_rd_rdy;
    logic        dat_wr_rdy;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [15:0] ins_stall_cnt;

    modport slave (
        input  ins_rd_addr, ins_rd_req, dat_rw_addr, dat_wr_data, dat_rd_req, dat_wr_req, mem_rdata,
        output ins_rd_data, ins_rd_rdy, dat_rd_data, dat_rd_rdy, dat_wr_rdy,
               mem_addr, mem_wdata, mem_re, mem_we, ins_stall_cnt
    );

    modport master (
        output ins_rd_addr, ins_rd_req, dat_rw_addr, dat_wr_data, dat_rd_req, dat_wr_req, mem_rdata,
        input  ins_rd_data, ins_rd_rdy, dat_rd_data, dat_rd_rdy, dat_wr_rdy,
               mem_addr, mem_wdata, mem_re, mem_we, ins_stall_cnt
    );
endinterface

// File: rtl/cpu16_mem_arb.sv
// cpu16_mem_arb: shares one single-port SRAM between cpu16 fetch and data ports, data first with bounded fetch starvation
module cpu16_mem_arb #(
    parameter int unsigned DATA_RUN_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    cpu16_mem_arb_if.slave bus
);
    typedef enum logic [1:0] {NONE, INS, DRD, DWR} grant_t;

    localparam logic [3:0] RUN_MAX = 4'(DATA_RUN_MAX);

    grant_t      r_last_grant;
    grant_t      w_grant;
    logic [3:0]  r_run_cnt;
    logic [3:0]  w_run_nxt;
    logic [15:0] r_stall_cnt;
    logic        r_ins_rdy;
    logic        r_drd_rdy;
    logic        r_dwr_rdy;
    logic        w_force;
    logic        w_dat;

    // Grant select: store over load over fetch, except a fetch is forced once the data run hits its limit; nothing is granted in reset
    always_comb begin
        w_force   = bus.ins_rd_req && (r_run_cnt == RUN_MAX);
        w_grant   = !reset          ? NONE :
                    w_force         ? INS  :
                    bus.dat_wr_req  ? DWR  :
                    bus.dat_rd_req  ? DRD  :
                    bus.ins_rd_req  ? INS  : NONE;
        w_dat     = (w_grant == DRD) || (w_grant == DWR);
        w_run_nxt = (!bus.ins_rd_req || w_grant == INS) ? 4'd0 :
                    w_dat ? r_run_cnt + 4'd1 : r_run_cnt;
    end

    assign bus.mem_re        = (w_grant == INS) || (w_grant == DRD);
    assign bus.mem_we        = w_grant == DWR;
    assign bus.mem_addr      = w_dat ? bus.dat_rw_addr : bus.ins_rd_addr;
    assign bus.mem_wdata     = bus.dat_wr_data;
    assign bus.ins_rd_data   = bus.mem_rdata;
    assign bus.dat_rd_data   = bus.mem_rdata;
    assign bus.ins_rd_rdy    = r_ins_rdy;
    assign bus.dat_rd_rdy    = r_drd_rdy;
    assign bus.dat_wr_rdy    = r_dwr_rdy;
    assign bus.ins_stall_cnt = r_stall_cnt;

    // Capture the grant, raise its dedicated ack flop next cycle and track the data run length
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= NONE;
            r_ins_rdy    <= 1'b0;
            r_drd_rdy    <= 1'b0;
            r_dwr_rdy    <= 1'b0;
            r_run_cnt    <= 4'd0;
        end else begin
            r_last_grant <= w_grant;
            r_ins_rdy    <= w_grant == INS;
            r_drd_rdy    <= w_grant == DRD;
            r_dwr_rdy    <= w_grant == DWR;
            r_run_cnt    <= w_run_nxt;
        end
    end

    // Count cycles a fetch waits without a grant, sticking at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_cnt <= 16'd0;
        else if (bus.ins_rd_req && w_grant != INS && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    a_ack_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0({r_ins_rdy, r_drd_rdy, r_dwr_rdy}) && (r_ins_rdy == (r_last_grant == INS)));
endmodule

// File: tb/tb_cpu16_mem_arb.sv
// tb_cpu16_mem_arb: directed vectors with a cycle-tagged scoreboard checked by a negedge monitor
module tb_cpu16_mem_arb;
    localparam int G_NONE = 0;
    localparam int G_INS  = 1;
    localparam int G_DRD  = 2;
    localparam int G_DWR  = 3;

    typedef struct {
        int          due;
        logic        re;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        int          st;
    } drv_t;

    typedef struct {
        int          due;
        logic [2:0]  rdy;
        logic [15:0] data;
    } ack_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_pass = 0;
    int   n_tot  = 0;

    drv_t q_drv[$];
    ack_t q_ack[$];

    logic [15:0] mem [256];
    logic [255:0] mem_wr = '0;

    cpu16_mem_arb_if bus();

    cpu16_mem_arb dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: untouched words read as C000|addr, one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[7:0]]    <= bus.mem_wdata;
            mem_wr[bus.mem_addr[7:0]] <= 1'b1;
        end
        if (bus.mem_re)
            bus.mem_rdata <= mem_wr[bus.mem_addr[7:0]] ? mem[bus.mem_addr[7:0]] : (16'hC000 | {8'h00, bus.mem_addr[7:0]});
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int ir, input logic [15:0] ia, input int dr, input int dw,
                        input logic [15:0] da, input logic [15:0] wd, input int g,
                        input logic [15:0] ed, input int st);
        @(posedge clk);
        #1;
        bus.ins_rd_req  = 1'(ir);
        bus.ins_rd_addr = ia;
        bus.dat_rd_req  = 1'(dr);
        bus.dat_wr_req  = 1'(dw);
        bus.dat_rw_addr = da;
        bus.dat_wr_data = wd;
        q_drv.push_back('{due: cyc, re: (g == G_INS || g == G_DRD), we: (g == G_DWR),
                          addr: (g == G_DRD || g == G_DWR) ? da : ia, wd: wd, st: st});
        if (g != G_NONE)
            q_ack.push_back('{due: cyc + 1, rdy: (g == G_INS) ? 3'b100 : (g == G_DRD) ? 3'b010 : 3'b001, data: ed});
    endtask

    // Monitor: compare SRAM drive and stall count for the current cycle, and acks/data due this cycle
    always @(negedge clk) begin
        drv_t d;
        ack_t a;
        logic [2:0] rdy;
        rdy = {bus.ins_rd_rdy, bus.dat_rd_rdy, bus.dat_wr_rdy};
        if (q_drv.size() != 0 && q_drv[0].due == cyc) begin
            d = q_drv.pop_front();
            chk("mem_re", {15'd0, bus.mem_re}, {15'd0, d.re});
            chk("mem_we", {15'd0, bus.mem_we}, {15'd0, d.we});
            chk("mem_addr", bus.mem_addr, d.addr);
            chk("mem_wdata", bus.mem_wdata, d.wd);
            if (d.st >= 0) chk("ins_stall_cnt", bus.ins_stall_cnt, 16'(d.st));
        end
        if (q_ack.size() != 0 && q_ack[0].due == cyc) begin
            a = q_ack.pop_front();
            chk("acks", {13'd0, rdy}, {13'd0, a.rdy});
            if (a.rdy[2]) chk("ins_rd_data", bus.ins_rd_data, a.data);
            if (a.rdy[1]) chk("dat_rd_data", bus.dat_rd_data, a.data);
        end else if (rdy != 3'b000) begin
            chk("unexpected_ack", {13'd0, rdy}, 16'd0);
        end
    end

    initial begin
        bus.ins_rd_req  = 1'b1;
        bus.ins_rd_addr = 16'h0000;
        bus.dat_rd_req  = 1'b1;
        bus.dat_wr_req  = 1'b1;
        bus.dat_rw_addr = 16'h0005;
        bus.dat_wr_data = 16'h5A5A;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_re", {15'd0, bus.mem_re}, 16'd0);
        chk("rst_mem_we", {15'd0, bus.mem_we}, 16'd0);
        chk("rst_acks", {13'd0, bus.ins_rd_rdy, bus.dat_rd_rdy, bus.dat_wr_rdy}, 16'd0);
        chk("rst_stall", bus.ins_stall_cnt, 16'd0);
        chk("rst_wdata", bus.mem_wdata, 16'h5A5A);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.ins_rd_req = 1'b0;
        bus.dat_rd_req = 1'b0;
        bus.dat_wr_req = 1'b0;

        // Back-to-back fetches at full throughput
        step(1, 16'h0000, 0, 0, 16'h0000, 16'h0000, G_INS, 16'hC000, 0);
        step(1, 16'h0001, 0, 0, 16'h0000, 16'h0000, G_INS, 16'hC001, 0);
        step(1, 16'h0002, 0, 0, 16'h0000, 16'h0000, G_INS, 16'hC002, 0);
        // Store then load the same word while a fetch waits; fetch dropped after its grant still acks
        step(1, 16'h0003, 0, 1, 16'h0010, 16'h1234, G_DWR, 16'h0000, 0);
        step(1, 16'h0003, 1, 0, 16'h0010, 16'h1234, G_DRD, 16'h1234, 1);
        step(1, 16'h0003, 0, 0, 16'h0000, 16'h0000, G_INS, 16'hC003, 2);
        step(0, 16'h0003, 0, 0, 16'h0000, 16'h0000, G_NONE, 16'h0000, 2);
        // Held load with fetch pending: every fifth cycle goes to the fetch
        for (int i = 0; i < 10; i++)
            step(1, (i < 5) ? 16'h0004 : 16'h0005, 1, 0, 16'h0020, 16'h0000,
                 (i % 5 == 4) ? G_INS : G_DRD,
                 (i % 5 == 4) ? ((i < 5) ? 16'hC004 : 16'hC005) : 16'hC020, 2 + i - i / 5);
        step(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, G_NONE, 16'h0000, 10);
        // Illegal read+write together: write first, read returns the new value
        step(0, 16'h0000, 1, 1, 16'h0030, 16'hABCD, G_DWR, 16'h0000, 10);
        step(0, 16'h0000, 1, 0, 16'h0030, 16'hABCD, G_DRD, 16'hABCD, 10);
        step(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, G_NONE, 16'h0000, 10);
        // Run counter reaches the limit, then clears when the fetch request drops
        step(1, 16'h0006, 1, 0, 16'h0020, 16'h0000, G_DRD, 16'hC020, 10);
        step(1, 16'h0006, 1, 0, 16'h0020, 16'h0000, G_DRD, 16'hC020, 11);
        step(1, 16'h0006, 1, 0, 16'h0020, 16'h0000, G_DRD, 16'hC020, 12);
        step(1, 16'h0006, 1, 0, 16'h0020, 16'h0000, G_DRD, 16'hC020, 13);
        step(0, 16'h0006, 1, 0, 16'h0020, 16'h0000, G_DRD, 16'hC020, 14);
        step(1, 16'h0006, 1, 0, 16'h0020, 16'h0000, G_DRD, 16'hC020, 14);
        step(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, G_NONE, 16'h0000, 15);

        // Reset pulse during a store grant: enables drop at once, no ack, no write
        @(posedge clk);
        #1;
        bus.ins_rd_req  = 1'b1;
        bus.ins_rd_addr = 16'h0041;
        bus.dat_wr_req  = 1'b1;
        bus.dat_rw_addr = 16'h0040;
        bus.dat_wr_data = 16'h5555;
        #1;
        chk("pre_rst_we", {15'd0, bus.mem_we}, 16'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_we", {15'd0, bus.mem_we}, 16'd0);
        chk("mid_rst_re", {15'd0, bus.mem_re}, 16'd0);
        chk("mid_rst_stall", bus.ins_stall_cnt, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.ins_rd_req = 1'b0;
        bus.dat_wr_req = 1'b0;
        step(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, G_INS, 16'hC040, 0);
        step(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, G_NONE, 16'h0000, 0);

        // Stall counter preset near the top, then driven into saturation
        @(negedge clk);
        #1;
        force dut.r_stall_cnt = 16'hFFF0;
        #1;
        release dut.r_stall_cnt;
        for (int i = 0; i < 40; i++)
            step(1, 16'h0007, 1, 0, 16'h0020, 16'h0000,
                 (i % 5 == 4) ? G_INS : G_DRD, (i % 5 == 4) ? 16'hC007 : 16'hC020,
                 (65520 + i - i / 5 > 65535) ? 65535 : 65520 + i - i / 5);
        step(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, G_NONE, 16'h0000, 65535);

        repeat (2) @(negedge clk);
        #1;
        chk("drv_queue_drained", 16'(q_drv.size()), 16'd0);
        chk("ack_queue_drained", 16'(q_ack.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
